// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl: direct-mapped cache tag controller.
// Looks up request tags in an asynchronous-read tag RAM. On a miss it requests a
// line fill from backing memory and then writes the new tag. After reset, and on
// a flush, it sweeps the whole tag RAM to invalidate every line.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        lookup request handshake, req_address = {tag, index, offset}
//   flush                      invalidate all lines (sampled in IDLE only)
//   resp_valid, resp_hit       one-cycle response pulse; hit=0 means the line was filled
//   fill_req, fill_address     line-fill request (line aligned), fill_done completes it
//   tagmem_*                   tag RAM port, entry = {valid, tag}; read data is combinational
module tag_lookup_ctrl #(
    parameter int unsigned ADDRESS_BITWIDTH = 32,
    parameter int unsigned INDEX_BITWIDTH   = 8,
    parameter int unsigned OFFSET_BITWIDTH  = 5,
    localparam int unsigned TAG_BITWIDTH    = ADDRESS_BITWIDTH - INDEX_BITWIDTH - OFFSET_BITWIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDRESS_BITWIDTH-1:0] req_address,
    input  logic                        flush,
    output logic                        resp_valid,
    output logic                        resp_hit,
    output logic                        fill_req,
    output logic [ADDRESS_BITWIDTH-1:0] fill_address,
    input  logic                        fill_done,
    output logic                        tagmem_write_enable,
    output logic [INDEX_BITWIDTH-1:0]   tagmem_address,
    output logic [TAG_BITWIDTH:0]       tagmem_data_in,
    input  logic [TAG_BITWIDTH:0]       tagmem_data_out
);

    localparam logic [ADDRESS_BITWIDTH-1:0] OFFSET_MASK =
        ADDRESS_BITWIDTH'((64'd1 << OFFSET_BITWIDTH) - 64'd1);

    typedef enum logic [2:0] {
        SWEEP,
        IDLE,
        COMPARE,
        FILL,
        WRITE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [INDEX_BITWIDTH-1:0]   sweep_cnt;
    logic [INDEX_BITWIDTH-1:0]   sweep_cnt_next;
    logic [ADDRESS_BITWIDTH-1:0] req_r;
    logic [ADDRESS_BITWIDTH-1:0] req_next;
    logic                        req_ready_next;
    logic                        resp_valid_next;
    logic                        resp_hit_next;
    logic                        fill_req_next;
    logic [ADDRESS_BITWIDTH-1:0] fill_address_next;

    logic [TAG_BITWIDTH-1:0]     req_tag;
    logic [INDEX_BITWIDTH-1:0]   req_index;
    logic                        tag_hit;

    // Field split of the captured request address.
    assign req_tag   = req_r[ADDRESS_BITWIDTH-1 -: TAG_BITWIDTH];
    assign req_index = req_r[OFFSET_BITWIDTH +: INDEX_BITWIDTH];
    assign tag_hit   = tagmem_data_out[TAG_BITWIDTH] &&
                       (tagmem_data_out[TAG_BITWIDTH-1:0] == req_tag);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SWEEP;
            sweep_cnt    <= '0;
            req_r        <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            fill_req     <= 1'b0;
            fill_address <= '0;
        end else begin
            state        <= state_next;
            sweep_cnt    <= sweep_cnt_next;
            req_r        <= req_next;
            req_ready    <= req_ready_next;
            resp_valid   <= resp_valid_next;
            resp_hit     <= resp_hit_next;
            fill_req     <= fill_req_next;
            fill_address <= fill_address_next;
        end
    end

    // Next-state logic, next values of registered outputs, and the tag RAM port.
    always_comb begin
        state_next          = state;
        sweep_cnt_next      = sweep_cnt;
        req_next            = req_r;
        resp_valid_next     = 1'b0;
        resp_hit_next       = 1'b0;
        fill_req_next       = 1'b0;
        fill_address_next   = fill_address;
        tagmem_write_enable = 1'b0;
        tagmem_address      = req_index;
        tagmem_data_in      = '0;

        case (state)
            SWEEP: begin
                tagmem_write_enable = 1'b1;
                tagmem_address      = sweep_cnt;
                // Counter wraps to zero on the last entry, ready for the next sweep.
                sweep_cnt_next      = sweep_cnt + INDEX_BITWIDTH'(1);
                if (&sweep_cnt) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                // Flush wins over a simultaneous request, which is left unaccepted.
                if (flush) begin
                    state_next     = SWEEP;
                    sweep_cnt_next = '0;
                end else if (req_valid) begin
                    req_next   = req_address;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (tag_hit) begin
                    resp_valid_next = 1'b1;
                    resp_hit_next   = 1'b1;
                    state_next      = IDLE;
                end else begin
                    fill_req_next     = 1'b1;
                    fill_address_next = req_r & ~OFFSET_MASK;
                    state_next        = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_next = WRITE;
                end else begin
                    fill_req_next = 1'b1;
                end
            end
            WRITE: begin
                tagmem_write_enable = 1'b1;
                tagmem_data_in      = {1'b1, req_tag};
                resp_valid_next     = 1'b1;
                state_next          = IDLE;
            end
            default: begin
                state_next     = SWEEP;
                sweep_cnt_next = '0;
            end
        endcase

        req_ready_next = (state_next == IDLE);
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Scoreboard bench for tag_lookup_ctrl with a small behavioural tag RAM.
module tb_tag_lookup_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned OW = 2;
    localparam int unsigned TW = AW - IW - OW;
    localparam int unsigned NENT = 1 << IW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_address;
    logic          flush;
    logic          resp_valid;
    logic          resp_hit;
    logic          fill_req;
    logic [AW-1:0] fill_address;
    logic          fill_done;
    logic          tagmem_write_enable;
    logic [IW-1:0] tagmem_address;
    logic [TW:0]   tagmem_data_in;
    logic [TW:0]   tagmem_data_out;

    int checks = 0;
    int errors = 0;

    // Expected traffic, pushed at accept time and popped when the DUT produces it.
    logic          resp_q [$];
    logic [AW-1:0] fill_q [$];
    logic [IW+TW:0] wr_q  [$];

    // Reference contents of the cache, independent of the RAM model.
    logic          model_v [NENT];
    logic [TW-1:0] model_t [NENT];

    logic [TW:0]   mem [NENT];
    logic          fill_req_d = 1'b0;
    logic [AW-1:0] fill_hold  = '0;

    tag_lookup_ctrl #(
        .ADDRESS_BITWIDTH(AW),
        .INDEX_BITWIDTH  (IW),
        .OFFSET_BITWIDTH (OW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_address        (req_address),
        .flush              (flush),
        .resp_valid         (resp_valid),
        .resp_hit           (resp_hit),
        .fill_req           (fill_req),
        .fill_address       (fill_address),
        .fill_done          (fill_done),
        .tagmem_write_enable(tagmem_write_enable),
        .tagmem_address     (tagmem_address),
        .tagmem_data_in     (tagmem_data_in),
        .tagmem_data_out    (tagmem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read, synchronous-write tag RAM.
    always @(posedge clk) begin
        if (tagmem_write_enable) mem[tagmem_address] <= tagmem_data_in;
    end
    assign tagmem_data_out = mem[tagmem_address];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Output monitor: responses, fill requests and tag writes against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else chk("resp_hit", 32'(resp_hit), 32'(resp_q.pop_front()));
            end
            if (fill_req && !fill_req_d) begin
                if (fill_q.size() == 0) chk("fill_unexpected", 32'd1, 32'd0);
                else chk("fill_address", 32'(fill_address), 32'(fill_q.pop_front()));
                fill_hold = fill_address;
            end else if (fill_req) begin
                chk("fill_hold", 32'(fill_address), 32'(fill_hold));
            end
            if (tagmem_write_enable && tagmem_data_in[TW]) begin
                if (wr_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
                else chk("tag_write", 32'({tagmem_address, tagmem_data_in}), 32'(wr_q.pop_front()));
            end
        end
        fill_req_d = rst_n ? fill_req : 1'b0;
    end

    task automatic model_clear();
        for (int i = 0; i < int'(NENT); i++) begin
            model_v[i] = 1'b0;
            model_t[i] = '0;
        end
    endtask

    // Called at the negedge of the first sweep cycle; ends at the first IDLE negedge.
    task automatic sweep_check();
        for (int i = 0; i < int'(NENT); i++) begin
            chk("sweep_ready", 32'(req_ready), 32'd0);
            chk("sweep_we", 32'(tagmem_write_enable), 32'd1);
            chk("sweep_addr", 32'(tagmem_address), 32'(i));
            chk("sweep_data", 32'(tagmem_data_in), 32'd0);
            @(negedge clk);
        end
        chk("sweep_done_ready", 32'(req_ready), 32'd1);
        model_clear();
    endtask

    // Issue one request at a negedge; fill_done is returned fill_delay cycles after
    // fill_req is first seen. exp_lat (if nonzero) is the negedge count from accept to resp.
    task automatic do_req(input logic [AW-1:0] a, input int fill_delay, input int exp_lat);
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        logic          hit;
        int            n;
        int            lat;
        int            seen;
        idx = a[OW +: IW];
        tg  = a[AW-1 -: TW];
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
        req_valid   = 1'b1;
        req_address = a;
        @(posedge clk);
        hit = model_v[idx] && (model_t[idx] == tg);
        resp_q.push_back(hit);
        if (!hit) begin
            fill_q.push_back({a[AW-1:OW], OW'(0)});
            wr_q.push_back({idx, 1'b1, tg});
            model_v[idx] = 1'b1;
            model_t[idx] = tg;
        end
        lat  = 0;
        seen = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            fill_done = 1'b0;
            if (resp_valid) break;
            if (fill_req) begin
                if (seen == fill_delay) fill_done = 1'b1;
                else seen++;
            end
        end
        fill_done = 1'b0;
        if (lat >= 60) chk("resp_timeout", 32'd0, 32'd1);
        else if (exp_lat != 0) chk("resp_latency", 32'(lat), 32'(exp_lat));
    endtask

    logic [TW-1:0] tag_set [3];
    logic [AW-1:0] ra;

    initial begin
        tag_set[0] = 10'h048;
        tag_set[1] = 10'h049;
        tag_set[2] = 10'h150;
        model_clear();
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_address = '0;
        flush       = 1'b0;
        fill_done   = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_fill_req", 32'(fill_req), 32'd0);
        chk("rst_fill_addr", 32'(fill_address), 32'd0);
        chk("rst_we", 32'(tagmem_write_enable), 32'd1);
        chk("rst_addr", 32'(tagmem_address), 32'd0);
        chk("rst_data", 32'(tagmem_data_in), 32'd0);
        rst_n = 1'b1;
        sweep_check();

        // Miss with delayed fill, then hits on the same line.
        do_req(16'h1234, 3, 0);
        do_req(16'h1234, 0, 2);
        do_req(16'h1236, 0, 2);
        // Same index, different tag: conflict misses both ways.
        do_req(16'h1274, 1, 0);
        do_req(16'h1234, 0, 4);
        do_req(16'h1234, 0, 2);

        // Mixed traffic over a few tags and indices.
        for (int i = 0; i < 24; i++) begin
            ra = {tag_set[$urandom_range(0, 2)], IW'($urandom_range(0, 3)), OW'($urandom_range(0, 3))};
            do_req(ra, int'($urandom_range(0, 3)), 0);
        end

        // Flush together with a request: request dropped, full sweep runs.
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_address = 16'h1234;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        sweep_check();
        do_req(16'h1234, 2, 0);
        do_req(16'h1234, 0, 2);

        // Reset in the middle of a fill.
        req_valid   = 1'b1;
        req_address = 16'h5678;
        @(posedge clk);
        fill_q.push_back(16'h5678);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !fill_req; n++) @(negedge clk);
        chk("abort_fill_req_high", 32'(fill_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_fill_req_drop", 32'(fill_req), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        fill_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check();
        chk("abort_late_fill_req", 32'(fill_req), 32'd0);
        fill_done = 1'b0;
        do_req(16'h5678, 0, 4);
        do_req(16'h5678, 0, 2);
        do_req(16'h1234, 1, 0);

        repeat (3) @(negedge clk);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        chk("fill_q_empty", 32'(fill_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tag_lookup_ctrl.md
# tag_lookup_ctrl

Cache tag controller that drives the single-port, asynchronous-read tag memory from the requester side. It accepts lookup requests, compares the stored tag against the request tag, and on a miss issues a line-fill request to the backing memory. When the fill completes it writes the new tag. After reset, and on a flush command, it sweeps the tag memory to invalidate every line. It sits between the CPU-side cache logic and the tag RAM instance.

## Interface
- ADDRESS_BITWIDTH, 32, width of the request address.
- INDEX_BITWIDTH, 8, line index width; equals the tag memory address width.
- OFFSET_BITWIDTH, 5, byte offset within a line.
- TAG_BITWIDTH, ADDRESS_BITWIDTH-INDEX_BITWIDTH-OFFSET_BITWIDTH, stored tag width. The tag entry is TAG_BITWIDTH+1 bits: {valid, tag}, with valid as the MSB.

- clk  in  1  the single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  lookup request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a clk edge.
- req_address  in  ADDRESS_BITWIDTH  lookup address.
- flush  in  1  invalidate all lines.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = hit, 0 = miss (line now filled); valid only while resp_valid is high.
- fill_req  out  1  line-fill request to backing memory.
- fill_address  out  ADDRESS_BITWIDTH  line-aligned fill address; offset bits are zero.
- fill_done  in  1  fill complete.
- tagmem_write_enable  out  1  tag RAM write enable.
- tagmem_address  out  INDEX_BITWIDTH  tag RAM address.
- tagmem_data_in  out  TAG_BITWIDTH+1  tag RAM write data.
- tagmem_data_out  in  TAG_BITWIDTH+1  tag RAM read data; combinational from tagmem_address.

## Operation
- The request address is split as {tag, index, offset}. The accepted address is held in a register, req_r.
- States and transitions:
  - SWEEP: entered on reset and from IDLE on flush. Writes 0 to tag RAM entry sweep_cnt, with sweep_cnt running 0 to 2^INDEX_BITWIDTH-1, one entry per cycle. After the last entry, go to IDLE.
  - IDLE: req_ready=1. If flush is high, go to SWEEP; flush has priority over a simultaneous req_valid, and that request is not accepted. Otherwise, if req_valid is high, capture req_address into req_r and go to COMPARE.
  - COMPARE: tagmem_address = req_r index. A hit is tagmem_data_out MSB = 1 and tagmem_data_out tag bits = req_r tag.
    - Hit: pulse resp_valid with resp_hit=1, go to IDLE.
    - Miss: go to FILL.
  - FILL: fill_req=1 and fill_address = req_r with offset bits zeroed, both held stable. When fill_done is high, go to WRITE.
  - WRITE: tagmem_write_enable=1, tagmem_address = req_r index, tagmem_data_in = {1'b1, req_r tag}. Pulse resp_valid with resp_hit=0, go to IDLE.
- flush is sampled only in IDLE and ignored in every other state; the requester holds flush until it observes req_ready drop.
- fill_done is ignored outside FILL.
- No replacement choice is made: the cache is direct-mapped, and a miss overwrites the indexed entry.
- In every state other than SWEEP and WRITE, tagmem_write_enable=0.

## Timing
- While rst_n is low:
  - State is SWEEP and sweep_cnt=0.
  - req_ready, resp_valid, resp_hit and fill_req are 0; fill_address is 0.
  - tagmem_write_enable=1, tagmem_address=0, tagmem_data_in=0. Writing zero to entry 0 is harmless.
- Reset asserted mid-operation aborts immediately: fill_req drops asynchronously and no response is produced. The sweep restarts from 0 after release.
- A sweep takes exactly 2^INDEX_BITWIDTH cycles with req_ready=0. IDLE is entered on the edge that writes the last entry.
- Hit latency: accept at edge E0, resp_valid high during the cycle after E1 (one cycle). req_ready is high again in that same cycle, so the peak rate is one request every 2 cycles.
- Miss timing:
  - fill_req rises after E1 and stays high through the cycle in which fill_done is sampled.
  - fill_req falls at edge F, and WRITE occupies the cycle after F.
  - The tag is written and resp_valid (hit=0) pulses from edge F+1.
  - The minimum miss latency, with fill_done high the first FILL cycle, is 4 edges from accept.
- resp_valid, resp_hit, fill_req and fill_address are registered. The tagmem_* outputs are combinational from state and registers.

## Test plan
Test parameters: ADDRESS_BITWIDTH=16, INDEX_BITWIDTH=4, OFFSET_BITWIDTH=2 (TAG_BITWIDTH=10).
- Reset, then release -> req_ready=0 for 16 cycles while tag RAM entries 0..15 are written 0x000 in order, then req_ready=1.
- Request 0x1234 (index 0xD, tag 0x048), fill_done returned 3 cycles after fill_req -> fill_address=0x1234; entry 13 written 0x448; one resp_valid pulse with resp_hit=0.
- Repeat 0x1234, then 0x1236 -> each gets resp_valid with resp_hit=1 two edges after accept; fill_req is never asserted.
- Request 0x1274 (index 0xD, tag 0x049) -> miss, entry 13 becomes 0x449; a following 0x1234 misses again.
- flush and req_valid high together in IDLE -> request not accepted and a 16-cycle sweep runs; afterwards 0x1234 misses.
- rst_n pulsed low while fill_req is high -> fill_req drops immediately, no resp_valid, the sweep restarts at entry 0, and a late fill_done is ignored.
